// File: rtl/dffram_dp.sv
// Dual-port flip-flop RAM with byte write enables and an optional zero-fill after reset.
// Port 0 reads and writes; port 1 only reads. Read latency is 1 + OUT_REG cycles.
// A disabled port, or an address at or above WORDS, returns 0 at the normal latency.
//
// Ports
//   CLK          single clock, rising edge
//   RST          synchronous active-high reset
//   EN0/WE0/A0   port 0 enable, byte write enables and address
//   Di0/Do0      port 0 write data and read data
//   EN1/A1/Do1   port 1 enable, address and read data
//   BUSY         high while the clear sequence runs; both ports are ignored then
module dffram_dp #(
  parameter int unsigned WORDS          = 256,
  parameter int unsigned BYTES          = 4,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW            = $clog2(WORDS),
  localparam int unsigned DW            = 8 * BYTES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN0,
  input  logic [BYTES-1:0] WE0,
  input  logic [AW-1:0]    A0,
  input  logic [DW-1:0]    Di0,
  output logic [DW-1:0]    Do0,
  input  logic             EN1,
  input  logic [AW-1:0]    A1,
  output logic [DW-1:0]    Do1,
  output logic             BUSY
);

  localparam logic [AW:0]   WordsW = (AW + 1)'(WORDS);
  localparam logic [AW-1:0] LastW  = AW'(WORDS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  // Set by reset; converts the first idle cycle after release into the start of a clear.
  logic          pend_q, pend_d;

  logic [DW-1:0] mem [WORDS];

  logic          ready, a0_ok, a1_ok, acc0, acc1, wr0;
  logic [DW-1:0] mask, old0, old1, merged0, rd0_d, rd1_d, rd0_q, rd1_q;

  // Ports are only accepted once the FSM is idle with no clear pending.
  assign ready = !RST && (state_q == StIdle) && !pend_q;
  assign a0_ok = ({1'b0, A0} < WordsW);
  assign a1_ok = ({1'b0, A1} < WordsW);
  assign acc0  = ready && EN0 && a0_ok;
  assign acc1  = ready && EN1 && a1_ok;
  assign wr0   = acc0 && (|WE0);
  assign BUSY  = (state_q == StClear);

  always_comb begin
    mask = '0;
    for (int k = 0; k < BYTES; k++) begin
      mask[8*k +: 8] = {8{WE0[k]}};
    end
  end

  always_comb begin
    old0 = '0;
    old1 = '0;
    if (a0_ok) old0 = mem[A0];
    if (a1_ok) old1 = mem[A1];
  end

  assign merged0 = (old0 & ~mask) | (Di0 & mask);

  always_comb begin
    rd0_d = '0;
    rd1_d = '0;
    if (acc0) rd0_d = (RDW_MODE != 0 && wr0) ? merged0 : old0;
    if (acc1) rd1_d = (RDW_MODE != 0 && wr0 && (A1 == A0)) ? merged0 : old1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StClear;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LastW) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= (CLEAR_ON_RESET != 0);
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // The array itself has no reset; only the clear sequence zeroes it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == StClear) begin
        mem[cnt_q] <= '0;
      end else if (wr0) begin
        for (int k = 0; k < BYTES; k++) begin
          if (WE0[k]) mem[A0][8*k +: 8] <= Di0[8*k +: 8];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] out0_q, out1_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        out0_q <= '0;
        out1_q <= '0;
      end else begin
        out0_q <= rd0_q;
        out1_q <= rd1_q;
      end
    end
    assign Do0 = out0_q;
    assign Do1 = out1_q;
  end else begin : g_no_out_reg
    assign Do0 = rd0_q;
    assign Do1 = rd1_q;
  end

endmodule

// File: tb/tb_dffram_dp.sv
// Directed bench for dffram_dp. Two instances share one stimulus stream:
//   A: WORDS=256, RDW_MODE=0 (old data), OUT_REG=0 -> read data one cycle after an access
//   B: WORDS=200, RDW_MODE=1 (write-through), OUT_REG=1 -> read data two cycles after
module tb_dffram_dp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN0, EN1;
  logic [3:0]  WE0;
  logic [7:0]  A0, A1;
  logic [31:0] Di0;
  logic [31:0] doa0, doa1, dob0, dob1;
  logic        busya, busyb;

  int checks = 0;
  int errors = 0;

  logic [31:0] ra0, ra1, rb0, rb1;
  int          na, nb, bad;

  always #5 CLK = ~CLK;

  dffram_dp #(
    .WORDS(256), .BYTES(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(doa0),
    .EN1(EN1), .A1(A1), .Do1(doa1), .BUSY(busya)
  );

  dffram_dp #(
    .WORDS(200), .BYTES(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(dob0),
    .EN1(EN1), .A1(A1), .Do1(dob1), .BUSY(busyb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    EN0 = 1'b0; EN1 = 1'b0; WE0 = 4'h0; A0 = 8'h0; A1 = 8'h0; Di0 = 32'h0;
  endtask

  // One access cycle followed by an idle cycle; captures A after the first edge and
  // B (one extra pipeline stage) after the second.
  task automatic op(input logic en0, input logic [3:0] we, input logic [7:0] a0,
                    input logic [31:0] d, input logic en1, input logic [7:0] a1);
    EN0 = en0; WE0 = we; A0 = a0; Di0 = d; EN1 = en1; A1 = a1;
    @(posedge CLK); #1;
    ra0 = doa0; ra1 = doa1;
    idle();
    @(posedge CLK); #1;
    rb0 = dob0; rb1 = dob1;
  endtask

  // Runs cycles after reset release, counting BUSY cycles per instance. While B is busy,
  // a write of 0x5A5A5A5A to word 3 plus a port 1 read are offered; they must be ignored.
  // Stops after stop_at busy cycles of A, when both are idle, or at the cycle budget.
  task automatic run_clear(input int stop_at);
    na = 0; nb = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 0 || busyb) begin
        EN0 = 1'b1; WE0 = 4'hF; A0 = 8'd3; Di0 = 32'h5A5A5A5A; EN1 = 1'b1; A1 = 8'd3;
      end else begin
        idle();
      end
      @(posedge CLK); #1;
      if (busya) na++;
      if (busyb) nb++;
      if (busya && (doa0 !== 32'h0 || doa1 !== 32'h0)) bad++;
      if (busyb && (dob0 !== 32'h0 || dob1 !== 32'h0)) bad++;
      if (na == stop_at) break;
      if (!busya && !busyb && i > 0) break;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_doa0", doa0, 32'h0);
    check("rst_doa1", doa1, 32'h0);
    check("rst_dob0", dob0, 32'h0);
    check("rst_dob1", dob1, 32'h0);
    check("rst_busya", {31'h0, busya}, 32'h0);
    check("rst_busyb", {31'h0, busyb}, 32'h0);
    @(posedge CLK); #1;

    // Clear sequence after release.
    RST = 1'b0;
    run_clear(-1);
    check("clear_len_a", na, 256);
    check("clear_len_b", nb, 200);
    check("busy_outputs_zero", bad, 0);
    check("busya_done", {31'h0, busya}, 32'h0);
    check("busyb_done", {31'h0, busyb}, 32'h0);

    for (int i = 0; i < 256; i++) begin
      op(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 8'(i));
      check($sformatf("zero_a1_%0d", i), ra1, 32'h0);
      check($sformatf("zero_b1_%0d", i), rb1, 32'h0);
    end

    // Byte writes to word 5; Do0 shows old data (A) or merged data (B).
    op(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 8'h0);
    check("bw1_a0", ra0, 32'h0);
    check("bw1_b0", rb0, 32'hAABBCCDD);
    op(1'b1, 4'h5, 8'd5, 32'h11223344, 1'b0, 8'h0);
    check("bw2_a0", ra0, 32'hAABBCCDD);
    check("bw2_b0", rb0, 32'hAA22CC44);
    op(1'b1, 4'h0, 8'd5, 32'hFFFFFFFF, 1'b0, 8'h0);
    check("bw_read_a0", ra0, 32'hAA22CC44);
    check("bw_read_b0", rb0, 32'hAA22CC44);

    // Read-during-write on word 9 from both ports.
    op(1'b1, 4'hF, 8'd9, 32'hFFFFFFFF, 1'b1, 8'd9);
    check("rdw_a0", ra0, 32'h0);
    check("rdw_a1", ra1, 32'h0);
    check("rdw_b0", rb0, 32'hFFFFFFFF);
    check("rdw_b1", rb1, 32'hFFFFFFFF);
    op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9);
    check("rdw_after_a1", ra1, 32'hFFFFFFFF);
    check("rdw_after_b1", rb1, 32'hFFFFFFFF);

    // Partial write to word 5 while port 1 reads it.
    op(1'b1, 4'h2, 8'd5, 32'h0000EE00, 1'b1, 8'd5);
    check("rdw_part_a1", ra1, 32'hAA22CC44);
    check("rdw_part_b1", rb1, 32'hAA22EE44);

    // EN1 low reads 0; EN0 with WE0=0 is a pure read.
    op(1'b1, 4'h0, 8'd5, 32'h12345678, 1'b0, 8'd5);
    check("en1_off_a1", ra1, 32'h0);
    check("en1_off_b1", rb1, 32'h0);
    check("pure_read_a0", ra0, 32'hAA22EE44);
    check("pure_read_b0", rb0, 32'hAA22EE44);
    op(1'b0, 4'hF, 8'd5, 32'h0, 1'b1, 8'd5);
    check("en0_off_a0", ra0, 32'h0);
    check("en0_off_b0", rb0, 32'h0);
    check("en0_off_nowrite_a1", ra1, 32'hAA22EE44);
    check("en0_off_nowrite_b1", rb1, 32'hAA22EE44);

    // Address 210: valid on A, out of range on B.
    op(1'b1, 4'hF, 8'd210, 32'h12345678, 1'b1, 8'd210);
    check("oor_wr_b0", rb0, 32'h0);
    check("oor_wr_b1", rb1, 32'h0);
    op(1'b1, 4'h0, 8'd210, 32'h0, 1'b1, 8'd210);
    check("oor_rd_a0", ra0, 32'h12345678);
    check("oor_rd_a1", ra1, 32'h12345678);
    check("oor_rd_b0", rb0, 32'h0);
    check("oor_rd_b1", rb1, 32'h0);
    op(1'b1, 4'h0, 8'd10, 32'h0, 1'b1, 8'd82);
    check("alias10_b0", rb0, 32'h0);
    check("alias82_b1", rb1, 32'h0);

    // Reset while a read is in B's pipeline discards it.
    EN0 = 1'b1; WE0 = 4'h0; A0 = 8'd5;
    @(posedge CLK); #1;
    check("flush_pre_a0", doa0, 32'hAA22EE44);
    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    check("flush_b0", dob0, 32'h0);
    check("flush_a0", doa0, 32'h0);

    // Abort the clear at cnt=100, then confirm it restarts from word 0.
    RST = 1'b0;
    run_clear(100);
    check("mid_count_a", na, 100);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_busya", {31'h0, busya}, 32'h0);
    check("abort_busyb", {31'h0, busyb}, 32'h0);
    RST = 1'b0;
    run_clear(-1);
    check("restart_len_a", na, 256);
    check("restart_len_b", nb, 200);
    check("restart_outputs_zero", bad, 0);

    op(1'b1, 4'h0, 8'd3, 32'h0, 1'b1, 8'd5);
    check("ignored_wr_a0", ra0, 32'h0);
    check("ignored_wr_b0", rb0, 32'h0);
    check("recleared_a1", ra1, 32'h0);
    check("recleared_b1", rb1, 32'h0);
    op(1'b1, 4'h0, 8'd210, 32'h0, 1'b1, 8'd9);
    check("recleared210_a0", ra0, 32'h0);
    check("recleared9_a1", ra1, 32'h0);
    check("recleared9_b1", rb1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dffram_dp.md
DFFRAM_DP -- requirements
Module: dffram_dp

Interface
REQ-001 SHALL have parameter WORDS, default 256: number of words; any value 2..4096, not necessarily a power of two.
REQ-002 SHALL have parameter BYTES, default 4: word width in bytes, so the data width is 8*BYTES.
REQ-003 SHALL have parameter RDW_MODE, default 0: read-during-write result. 0 = old data; 1 = write-through, returning the merged new data.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds an output pipeline register to both read ports.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills the array after reset.
REQ-006 SHALL have local AW = $clog2(WORDS).
REQ-007 SHALL have port CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port EN0, input, 1: port 0 (read/write) enable.
REQ-010 SHALL have port WE0, input, BYTES: port 0 byte write enables; qualified by EN0.
REQ-011 SHALL have port A0, input, AW: port 0 address.
REQ-012 SHALL have port Di0, input, 8*BYTES: port 0 write data.
REQ-013 SHALL have port Do0, output, 8*BYTES: port 0 read data.
REQ-014 SHALL have port EN1, input, 1: port 1 (read-only) enable.
REQ-015 SHALL have port A1, input, AW: port 1 address.
REQ-016 SHALL have port Do1, output, 8*BYTES: port 1 read data.
REQ-017 SHALL have port BUSY, output, 1: high while the clear sequence runs; both ports are ignored while BUSY is high.

Function
REQ-018 Read latency SHALL be 1+OUT_REG cycles from an enabled port cycle to valid Do0/Do1.
REQ-019 A cycle with the port enable low SHALL produce Do = 0 at the same latency; there is no hold of the previous data.
REQ-020 A port 0 cycle with EN0=1 SHALL write byte k of Di0 to word A0 only where WE0[k]=1 and SHALL leave the other bytes unchanged.
REQ-021 A port 0 cycle with WE0=0 and EN0=1 SHALL be a pure read.
REQ-022 Port 0 read of the word it is writing in the same cycle SHALL return the old word when RDW_MODE=0, and the byte-merged new word when RDW_MODE=1.
REQ-023 Port 1 read of A1==A0 while port 0 writes that word in the same cycle SHALL follow the same RDW_MODE rule as REQ-022.
REQ-024 An address >= WORDS SHALL suppress the write and SHALL read as 0; no aliasing onto a valid word.
REQ-025 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-026 The first cycle after RST deasserts SHALL enter CLEAR when CLEAR_ON_RESET=1, and IDLE otherwise.
REQ-027 In CLEAR, the FSM SHALL write 0 to word cnt once per cycle, cnt running 0..WORDS-1, and SHALL move to IDLE after word WORDS-1, giving exactly WORDS cycles with BUSY=1.
REQ-028 During BUSY, EN0, EN1 and WE0 SHALL be ignored, and Do0/Do1 SHALL read 0 at normal latency.
REQ-029 The first port access accepted SHALL be in the cycle in which BUSY is first low.
REQ-030 The array SHALL have no reset other than the clear sequence; with CLEAR_ON_RESET=0 its contents are undefined until written.

Reset
REQ-031 While RST=1, Do0, Do1 and the OUT_REG pipeline registers SHALL be 0 from the first clock edge with RST high.
REQ-032 While RST=1, BUSY SHALL be 0, the FSM SHALL be in IDLE, and cnt SHALL be 0.
REQ-033 RST asserted during CLEAR SHALL abort the sequence; the sequence SHALL restart from word 0 after release.
REQ-034 RST asserted mid-access SHALL discard any pending pipeline data.
REQ-035 A write in the same cycle as RST=1 SHALL NOT be performed.

Verification
REQ-036 Clear sequence, WORDS=256, CLEAR_ON_RESET=1: RST for 2 cycles, release -> BUSY=1 for exactly 256 cycles; afterwards a port 1 read of every address returns 0x00000000.
REQ-037 Byte write: write 0xAABBCCDD with WE0=1111 to word 5, then 0x11223344 with WE0=0101 -> port 0 read of word 5 returns 0xAA22CC44 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-038 Read-during-write: word 9 holds 0x0; port 0 writes 0xFFFFFFFF to word 9 while port 1 reads word 9 -> Do1 = 0x0 with RDW_MODE=0, 0xFFFFFFFF with RDW_MODE=1; Do0 follows the same rule.
REQ-039 Enables and range: EN1=0 -> Do1=0 next cycle. WORDS=200, write to address 210 -> no array word changes and a read of 210 returns 0.
REQ-040 Reset mid-clear: RST pulsed when cnt=100 -> BUSY drops; after release BUSY is high again for the full WORDS cycles. Accesses issued during BUSY are ignored: a write of 0x5A5A5A5A to word 3 leaves word 3 = 0.
